// File: rtl/disc_write_sequencer.sv
// Executes a byte-coded write program: write pulses, write gate, timer, index-count and track-mark waits.
// All outputs registered; single-step opcodes take 2+FETCH_LAT clocks DECODE-to-DECODE; abort returns to IDLE next edge.
module disc_write_sequencer #(
    parameter int TIMER_WIDTH = 12,
    parameter int PULSE_CLKS  = 30,
    parameter int FETCH_LAT   = 1,
    parameter int IDX_WIDTH   = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [7:0] mdat_i,
    output logic       maddr_inc_o,
    output logic       wrdata_o,
    output logic       wrgate_o,
    input  logic       trkmark_i,
    input  logic       index_i,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       running_o,
    output logic       aborted_o
);
    localparam int HI_W = (TIMER_WIDTH > 7) ? TIMER_WIDTH - 7 : 1;
    localparam int PCW  = $clog2(PULSE_CLKS + 1);
    localparam int FCW  = (FETCH_LAT > 1) ? $clog2(FETCH_LAT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_TIMERWAIT,
        S_INDEXWAIT,
        S_TRKWAIT,
        S_ADV,
        S_FETCH
    } state_t;

    state_t                 state_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [IDX_WIDTH-1:0]   idx_cnt_q;
    logic [HI_W-1:0]        hi_q;
    logic [FCW-1:0]         fetch_q;
    logic [PCW-1:0]         pulse_cnt_q;
    logic [PCW-1:0]         pulse_cnt_d;
    logic [2:0]             idx_sync_q;
    logic                   maddr_inc_q;
    logic                   wrdata_q;
    logic                   wrgate_q;
    logic                   running_q;
    logic                   aborted_q;

    logic                   op_timer;
    logic                   op_stop;
    logic                   op_index;
    logic                   op_hi;
    logic                   op_trk;
    logic                   op_pulse;
    logic                   op_gate;
    logic                   kill;
    logic                   pulse_fire;
    logic                   idx_rise;
    logic [HI_W+6:0]        timer_full;
    logic [TIMER_WIDTH-1:0] timer_load;

    assign op_timer   = mdat_i[7];
    assign op_stop    = (mdat_i == 8'h7F);
    assign op_index   = (mdat_i[7:6] == 2'b01) && !op_stop;
    assign op_hi      = (mdat_i[7:5] == 3'b001);
    assign op_trk     = (mdat_i == 8'h03);
    assign op_pulse   = (mdat_i == 8'h02);
    assign op_gate    = (mdat_i[7:1] == 7'd0);

    // Abort only acts once the engine has left IDLE, so start wins a tie in IDLE.
    assign kill       = abort_i && (state_q != S_IDLE);
    assign pulse_fire = (state_q == S_DECODE) && op_pulse && !kill;
    assign idx_rise   = idx_sync_q[1] & ~idx_sync_q[2];
    assign timer_full = {hi_q, mdat_i[6:0]};
    assign timer_load = timer_full[TIMER_WIDTH-1:0];

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            idx_sync_q <= 3'b000;
        end else begin
            idx_sync_q <= {idx_sync_q[1:0], index_i};
        end
    end

    // Retriggering reload keeps wrdata low without a gap between back-to-back pulses.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (kill) begin
            pulse_cnt_d = '0;
        end else if (pulse_fire) begin
            pulse_cnt_d = PCW'(PULSE_CLKS);
        end else if (pulse_cnt_q != '0) begin
            pulse_cnt_d = pulse_cnt_q - PCW'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            pulse_cnt_q <= '0;
            wrdata_q    <= 1'b1;
        end else begin
            pulse_cnt_q <= pulse_cnt_d;
            wrdata_q    <= (pulse_cnt_d == '0);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            idx_cnt_q   <= '0;
            hi_q        <= '0;
            fetch_q     <= '0;
            maddr_inc_q <= 1'b0;
            wrgate_q    <= 1'b1;
            running_q   <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            maddr_inc_q <= 1'b0;
            if (kill) begin
                state_q   <= S_IDLE;
                wrgate_q  <= 1'b1;
                running_q <= 1'b0;
                aborted_q <= 1'b1;
                timer_q   <= '0;
                idx_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            state_q   <= S_DECODE;
                            running_q <= 1'b1;
                            aborted_q <= 1'b0;
                            hi_q      <= '0;
                        end
                    end
                    S_DECODE: begin
                        if (op_timer) begin
                            timer_q <= timer_load;
                            hi_q    <= '0;
                            state_q <= S_TIMERWAIT;
                        end else if (op_stop) begin
                            wrgate_q  <= 1'b1;
                            running_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else if (op_index) begin
                            idx_cnt_q <= mdat_i[IDX_WIDTH-1:0];
                            state_q   <= S_INDEXWAIT;
                        end else if (op_trk) begin
                            state_q <= S_TRKWAIT;
                        end else begin
                            if (op_hi && (TIMER_WIDTH > 7)) begin
                                hi_q <= mdat_i[HI_W-1:0];
                            end
                            if (op_gate) begin
                                wrgate_q <= ~mdat_i[0];
                            end
                            maddr_inc_q <= 1'b1;
                            state_q     <= S_ADV;
                        end
                    end
                    S_TIMERWAIT: begin
                        // Exiting at 1 gives exactly T wait clocks, and T=0 costs the same as T=1.
                        if (timer_q <= TIMER_WIDTH'(1)) begin
                            timer_q     <= '0;
                            maddr_inc_q <= 1'b1;
                            state_q     <= S_ADV;
                        end else begin
                            timer_q <= timer_q - TIMER_WIDTH'(1);
                        end
                    end
                    S_INDEXWAIT: begin
                        if (idx_cnt_q == '0) begin
                            maddr_inc_q <= 1'b1;
                            state_q     <= S_ADV;
                        end else if (idx_rise) begin
                            idx_cnt_q <= idx_cnt_q - IDX_WIDTH'(1);
                        end
                    end
                    S_TRKWAIT: begin
                        if (trkmark_i) begin
                            maddr_inc_q <= 1'b1;
                            state_q     <= S_ADV;
                        end
                    end
                    S_ADV: begin
                        if (FETCH_LAT == 0) begin
                            state_q <= S_DECODE;
                        end else begin
                            fetch_q <= FCW'(FETCH_LAT);
                            state_q <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (fetch_q <= FCW'(1)) begin
                            state_q <= S_DECODE;
                        end else begin
                            fetch_q <= fetch_q - FCW'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign maddr_inc_o = maddr_inc_q;
    assign wrdata_o    = wrdata_q;
    assign wrgate_o    = wrgate_q;
    assign running_o   = running_q;
    assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_disc_write_sequencer.sv
// Bench for disc_write_sequencer: opcode table, cycle-level waveform model for whole programs, and corner sequences.
module tb_disc_write_sequencer;
    localparam int PULSE = 30;
    localparam int FL    = 1;
    localparam int MAXC  = 2048;
    localparam int WIN   = 170;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] mdat;
    logic       maddr_inc;
    logic       wrdata;
    logic       wrgate;
    logic       trkmark;
    logic       index;
    logic       start;
    logic       abort;
    logic       running;
    logic       aborted;

    always #5 clock = ~clock;

    disc_write_sequencer #(
        .TIMER_WIDTH(12),
        .PULSE_CLKS (PULSE),
        .FETCH_LAT  (FL),
        .IDX_WIDTH  (6)
    ) dut (
        .clock_i    (clock),
        .reset_i    (reset_n),
        .mdat_i     (mdat),
        .maddr_inc_o(maddr_inc),
        .wrdata_o   (wrdata),
        .wrgate_o   (wrgate),
        .trkmark_i  (trkmark),
        .index_i    (index),
        .start_i    (start),
        .abort_i    (abort),
        .running_o  (running),
        .aborted_o  (aborted)
    );

    // Track memory: address register advanced by maddr_inc, data read combinationally.
    logic [7:0] mem [0:255];
    logic [7:0] addr = 8'd0;
    assign mdat = mem[addr];
    always @(posedge clock) begin
        if (maddr_inc) addr <= addr + 8'd1;
    end

    int checks   = 0;
    int failures = 0;

    logic [7:0] prog_q [$];
    int         trk_at;

    logic exp_run  [0:MAXC-1];
    logic exp_madv [0:MAXC-1];
    logic exp_gate [0:MAXC-1];
    logic exp_data [0:MAXC-1];
    logic obs_run  [0:MAXC-1];
    logic obs_madv [0:MAXC-1];
    logic obs_gate [0:MAXC-1];
    logic obs_data [0:MAXC-1];

    typedef struct {
        logic [7:0] op;
        int         run;
        int         madv;
        int         gate_lo;
        int         data_lo;
    } vec_t;
    vec_t tbl [14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog_q.size(); i++) mem[8'(int'(addr) + i)] = prog_q[i];
    endtask

    // Cycle c is the clock period after the c-th edge following start; cycle 1 is the first DECODE.
    task automatic build_model(output int endc);
        int c, t, dur, hi, tv, cp, stop_c;
        logic gate;
        logic [7:0] op;
        for (int i = 0; i < MAXC; i++) begin
            exp_run[i] = 1'b0; exp_madv[i] = 1'b0; exp_gate[i] = 1'b1; exp_data[i] = 1'b1;
        end
        c = 1; hi = 0; gate = 1'b1; stop_c = 1;
        for (int k = 0; k < prog_q.size(); k++) begin
            op = prog_q[k];
            t  = c;
            if (op == 8'h7F) begin
                stop_c     = t;
                exp_run[t] = 1'b1;
                break;
            end
            dur = 2 + FL;
            if (op[7]) begin
                tv  = hi * 128 + int'(op[6:0]);
                hi  = 0;
                dur = 1 + ((tv > 1) ? tv : 1) + 1 + FL;
            end else if (op[7:6] == 2'b01) begin
                dur = 3 + FL;
            end else if (op[7:5] == 3'b001) begin
                hi = int'(op[4:0]);
            end else if (op == 8'h03) begin
                cp  = (trk_at > t + 1) ? trk_at : t + 1;
                dur = cp + 2 + FL - t;
            end else if (op == 8'h02) begin
                for (int p = 1; p <= PULSE; p++) exp_data[t + p] = 1'b0;
            end else if (op[7:1] == 7'd0) begin
                gate = ~op[0];
            end
            for (int cc = t; cc < t + dur; cc++) exp_run[cc] = 1'b1;
            for (int cc = t + 1; cc <= t + dur; cc++) exp_gate[cc] = gate;
            exp_madv[t + dur - 1 - FL] = 1'b1;
            c = t + dur;
        end
        endc = stop_c + PULSE + 4;
    endtask

    task automatic capture(input int endc);
        start   = 1'b1;
        trkmark = (trk_at <= 0);
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= endc; c++) begin
            obs_run[c]  = running;
            obs_madv[c] = maddr_inc;
            obs_gate[c] = wrgate;
            obs_data[c] = wrdata;
            trkmark     = (c >= trk_at);
            @(negedge clock);
        end
        trkmark = 1'b0;
    endtask

    task automatic cmp_wave(input string name, input int sel, input int endc);
        int bad, first;
        logic a, e, fa, fe;
        bad = 0; first = -1; fa = 1'b0; fe = 1'b0;
        for (int c = 1; c <= endc; c++) begin
            case (sel)
                0:       begin a = obs_run[c];  e = exp_run[c];  end
                1:       begin a = obs_madv[c]; e = exp_madv[c]; end
                2:       begin a = obs_gate[c]; e = exp_gate[c]; end
                default: begin a = obs_data[c]; e = exp_data[c]; end
            endcase
            if (a !== e) begin
                bad++;
                if (first < 0) begin first = c; fa = a; fe = e; end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: %0d cycles differ, first at cycle %0d got %0b expected %0b",
                     name, bad, first, fa, fe);
        end
    endtask

    task automatic run_prog(input string name);
        int endc;
        load_prog();
        build_model(endc);
        capture(endc);
        cmp_wave({name, ".running"},   0, endc);
        cmp_wave({name, ".maddr_inc"}, 1, endc);
        cmp_wave({name, ".wrgate"},    2, endc);
        cmp_wave({name, ".wrdata"},    3, endc);
    endtask

    initial begin
        int n_run, n_madv, n_glo, n_dlo, n_ops, first;

        tbl[0]  = '{8'h85, 9,   1, 0, 0};
        tbl[1]  = '{8'h80, 5,   1, 0, 0};
        tbl[2]  = '{8'h81, 5,   1, 0, 0};
        tbl[3]  = '{8'hFF, 131, 1, 0, 0};
        tbl[4]  = '{8'h01, 4,   1, 3, 0};
        tbl[5]  = '{8'h00, 4,   1, 0, 0};
        tbl[6]  = '{8'h02, 4,   1, 0, 30};
        tbl[7]  = '{8'h40, 5,   1, 0, 0};
        tbl[8]  = '{8'h03, 5,   1, 0, 0};
        tbl[9]  = '{8'h04, 4,   1, 0, 0};
        tbl[10] = '{8'h25, 4,   1, 0, 0};
        tbl[11] = '{8'h7F, 1,   0, 0, 0};
        tbl[12] = '{8'h1F, 4,   1, 0, 0};
        tbl[13] = '{8'h20, 4,   1, 0, 0};

        for (int i = 0; i < 256; i++) mem[i] = 8'h7F;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; trkmark = 1'b0; index = 1'b0; trk_at = 0;
        repeat (3) @(negedge clock);
        check("reset_maddr_inc", int'(maddr_inc), 0);
        check("reset_wrdata",    int'(wrdata),    1);
        check("reset_wrgate",    int'(wrgate),    1);
        check("reset_running",   int'(running),   0);
        check("reset_aborted",   int'(aborted),   0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single-opcode programs followed by STOP.
        for (int i = 0; i < 14; i++) begin
            prog_q = '{tbl[i].op, 8'h7F};
            trk_at = 0;
            load_prog();
            capture(WIN);
            n_run = 0; n_madv = 0; n_glo = 0; n_dlo = 0;
            for (int c = 1; c <= WIN; c++) begin
                n_run  += int'(obs_run[c]);
                n_madv += int'(obs_madv[c]);
                n_glo  += int'(!obs_gate[c]);
                n_dlo  += int'(!obs_data[c]);
            end
            check($sformatf("tbl%0d_op%02h_run",  i, tbl[i].op), n_run,  tbl[i].run);
            check($sformatf("tbl%0d_op%02h_madv", i, tbl[i].op), n_madv, tbl[i].madv);
            check($sformatf("tbl%0d_op%02h_glo",  i, tbl[i].op), n_glo,  tbl[i].gate_lo);
            check($sformatf("tbl%0d_op%02h_dlo",  i, tbl[i].op), n_dlo,  tbl[i].data_lo);
        end

        prog_q = '{8'h01, 8'h02, 8'h85, 8'h00, 8'h7F}; trk_at = 0;
        run_prog("basic_prog");
        prog_q = '{8'h25, 8'hFF, 8'h81, 8'h7F}; trk_at = 0;
        run_prog("timer_high");
        prog_q = '{8'h02, 8'h02, 8'h7F}; trk_at = 0;
        run_prog("retrigger");
        prog_q = '{8'h01, 8'h02, 8'h03, 8'h02, 8'h7F}; trk_at = 50;
        run_prog("trkmark_50");

        for (int r = 0; r < 15; r++) begin
            prog_q.delete();
            n_ops = $urandom_range(1, 5);
            for (int k = 0; k < n_ops; k++) begin
                case ($urandom_range(0, 7))
                    0:       prog_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
                    1:       prog_q.push_back(8'h20 | 8'($urandom_range(0, 1)));
                    2:       prog_q.push_back(8'h02);
                    3:       prog_q.push_back(8'($urandom_range(0, 1)));
                    4:       prog_q.push_back(8'h40);
                    5:       prog_q.push_back(8'h03);
                    6:       prog_q.push_back(8'($urandom_range(4, 31)));
                    default: prog_q.push_back(8'h80 | 8'($urandom_range(0, 7)));
                endcase
            end
            prog_q.push_back(8'h7F);
            trk_at = $urandom_range(0, 60);
            run_prog($sformatf("rand%0d", r));
        end

        // WAIT INDEX 3: an edge coincident with DECODE is ignored, then three index rises.
        prog_q = '{8'h43, 8'h7F};
        load_prog();
        first = -1; n_madv = 0;
        index = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 320; c++) begin
            if (maddr_inc) begin
                n_madv++;
                if (first < 0) first = c;
            end
            index = (c < 10) || (c >= 100 && c < 110) || (c >= 200 && c < 210) || (c >= 300 && c < 310);
            start = (c == 50);
            @(negedge clock);
        end
        index = 1'b0;
        start = 1'b0;
        check("index_madv_cycle", first, 304);
        check("index_madv_count", n_madv, 1);
        check("index_done_running", int'(running), 0);

        // Abort in TIMERWAIT with gate on and a pulse in flight.
        prog_q = '{8'h01, 8'h02, 8'h90, 8'h7F};
        load_prog();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("abort_pre_running", int'(running), 1);
        check("abort_pre_wrgate",  int'(wrgate),  0);
        check("abort_pre_wrdata",  int'(wrdata),  0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_wrgate",    int'(wrgate),    1);
        check("abort_wrdata",    int'(wrdata),    1);
        check("abort_running",   int'(running),   0);
        check("abort_aborted",   int'(aborted),   1);
        check("abort_maddr_inc", int'(maddr_inc), 0);
        abort = 1'b1;
        repeat (3) @(negedge clock);
        abort = 1'b0;
        check("abort_idle_sticky",  int'(aborted), 1);
        check("abort_idle_running", int'(running), 0);
        prog_q = '{8'h7F};
        load_prog();
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        check("start_wins_running", int'(running), 1);
        check("start_wins_aborted", int'(aborted), 0);
        @(negedge clock);
        check("stop_only_running", int'(running), 0);
        check("stop_only_aborted", int'(aborted), 0);

        // Asynchronous reset during INDEXWAIT.
        prog_q = '{8'h01, 8'h02, 8'h43, 8'h7F};
        load_prog();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("rst_pre_wrgate",  int'(wrgate),  0);
        check("rst_pre_running", int'(running), 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_maddr_inc", int'(maddr_inc), 0);
        check("rst_async_wrdata",    int'(wrdata),    1);
        check("rst_async_wrgate",    int'(wrgate),    1);
        check("rst_async_running",   int'(running),   0);
        check("rst_async_aborted",   int'(aborted),   0);
        start = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_start_ignored", int'(running), 0);
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clock);
        check("rst_release_running", int'(running), 0);
        check("rst_release_wrdata",  int'(wrdata),  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
